// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_t;

  // Simulation timing collapses a bit to a single clock.
  function automatic int unsigned bit_cyc_f(input bit test,
                                            input int unsigned clk_freq,
                                            input int unsigned baud);
    return test ? 32'd1 : clk_freq / baud;
  endfunction

  function automatic int unsigned half_f(input int unsigned bit_cyc);
    return bit_cyc / 2;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx.sv
// UART receiver: start-edge detect, mid-bit sampling, stop-bit framing check.
// rx_state exposes the FSM state for observation.
module rx
  import uart_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int          stop_bit = 2,
  parameter bit          test     = 1'b0,
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic             rx_clk,
  input  logic             rx_rst_n,
  input  logic             rx_data_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_done,
  output logic             rx_err,
  output rx_state_t        rx_state
);

  localparam int unsigned BIT_CYC = bit_cyc_f(test, CLK_FREQ, BAUD);
  localparam int unsigned HALF    = half_f(BIT_CYC);
  localparam int CNT_W = $clog2(BIT_CYC + 1);
  localparam int IDX_W = $clog2(WIDTH + stop_bit + 1);
  localparam logic [CNT_W-1:0] BIT_CYC_C = CNT_W'(BIT_CYC);
  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(WIDTH + stop_bit - 1);

  logic             rxd_s;
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] shreg, shreg_n, data_n;
  logic             done_n, err_n;

  rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (rx_clk),
    .rst_n (rx_rst_n),
    .d     (rx_data_in),
    .q     (rxd_s)
  );

  assign rx_state = state;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      rx_data <= '0;
      rx_done <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      rx_data <= data_n;
      rx_done <= done_n;
      rx_err  <= err_n;
    end
  end

  // cnt holds cycles elapsed since the previous sample point (or the start edge).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = rx_data;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          cnt_n = CNT_ONE;
          idx_n = '0;
          // With HALF = 0 the start sample is the edge cycle itself.
          state_n = (HALF_C == '0) ? DATA : START;
        end
      end
      START: begin
        if (cnt == HALF_C) begin
          cnt_n   = CNT_ONE;
          state_n = rxd_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == BIT_CYC_C) begin
          cnt_n   = CNT_ONE;
          shreg_n = {rxd_s, shreg[WIDTH-1:1]};
          idx_n   = idx + IDX_ONE;
          if (idx == LAST_DATA) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == BIT_CYC_C) begin
          cnt_n = CNT_ONE;
          idx_n = idx + IDX_ONE;
          if (!rxd_s) begin
            err_n   = 1'b1;
            state_n = WAIT_HI;
          end else if (idx == LAST_STOP) begin
            done_n  = 1'b1;
            data_n  = shreg;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
